// File: rtl/spu_pkg.sv
// Shared encodings for the SPU register file: immediate-load modes,
// clear-sequencer states and the per-word immediate expansion helper.
package spu_pkg;

  typedef enum logic [1:0] {
    IMM_ILH  = 2'b00,
    IMM_IL   = 2'b01,
    IMM_ILHU = 2'b10,
    IMM_RSV  = 2'b11
  } imm_mode_t;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int IMM_BITS  = 16;
  localparam int WORD_BITS = 32;

  // Expand a 16-bit immediate into one 32-bit word for the given load mode.
  function automatic logic [WORD_BITS-1:0] imm_word(input logic [IMM_BITS-1:0] i16,
                                                    input imm_mode_t          mode);
    logic [WORD_BITS-1:0] word;
    case (mode)
      IMM_ILH:  word = {i16, i16};
      IMM_IL:   word = {{IMM_BITS{i16[IMM_BITS-1]}}, i16};
      IMM_ILHU: word = {i16, 16'h0000};
      IMM_RSV:  word = 32'h0000_0000;
      default:  word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Reserved mode is the only encoding that must not write the register file.
  function automatic logic imm_mode_valid(input imm_mode_t mode);
    logic ok;
    case (mode)
      IMM_ILH, IMM_IL, IMM_ILHU: ok = 1'b1;
      IMM_RSV:                   ok = 1'b0;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/spu_imm_expand.sv
// Combinational immediate expander: replicates the expanded 32-bit word
// across the full register width and flags whether the mode writes at all.
module spu_imm_expand
  import spu_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic [15:0]      i_i16,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_value,
  output logic             o_valid
);

  localparam int NWORD = WIDTH / WORD_BITS;

  imm_mode_t              w_mode;
  logic [WORD_BITS-1:0]   w_word;

  assign w_mode = imm_mode_t'(i_mode);

  // Build one word from the immediate, then broadcast it to every word slot.
  always_comb begin
    w_word  = imm_word(i_i16, w_mode);
    o_valid = imm_mode_valid(w_mode);
    o_value = {NWORD{w_word}};
  end

endmodule

// File: rtl/spu_regfile_dp.sv
// Dual-pipe SPU general register file with NRD registered read ports,
// even/odd write ports, immediate-load path on the even slot, same-cycle
// write-to-read bypass and a hardware clear sequencer that zeroes every
// entry after reset or on request.
module spu_regfile_dp
  import spu_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int REGBITS = 7,
  parameter int NRD     = 4,
  parameter int ZERO_R0 = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRD*REGBITS-1:0] ra,
  output logic [NRD*WIDTH-1:0]   rd,
  input  logic                   we_e,
  input  logic [REGBITS-1:0]     wa_e,
  input  logic [WIDTH-1:0]       wd_e,
  input  logic                   we_o,
  input  logic [REGBITS-1:0]     wa_o,
  input  logic [WIDTH-1:0]       wd_o,
  input  logic                   imm_en,
  input  logic [1:0]             imm_mode,
  input  logic [REGBITS-1:0]     rt,
  input  logic [15:0]            i16,
  input  logic                   clr_req,
  output logic                   busy,
  output logic                   wcoll
);

  localparam int                 DEPTH    = 1 << REGBITS;
  localparam logic [REGBITS-1:0] CNT_LAST = REGBITS'(DEPTH - 1);
  localparam logic [REGBITS-1:0] CNT_ONE  = {{(REGBITS-1){1'b0}}, 1'b1};
  localparam logic [REGBITS-1:0] ADDR_R0  = {REGBITS{1'b0}};

  // Storage is deliberately not reset: the clear sequencer owns initialisation.
  logic [WIDTH-1:0]   r_mem [DEPTH];

  rf_state_t          r_state;
  rf_state_t          w_state_nxt;
  logic [REGBITS-1:0] r_cnt;
  logic [REGBITS-1:0] w_cnt_nxt;
  logic               r_busy;
  logic               r_wcoll;

  logic               w_clear;
  logic [WIDTH-1:0]   w_imm_value;
  logic               w_imm_valid;
  logic               w_imm_take;

  logic               w_ev_req;
  logic [REGBITS-1:0] w_ev_addr;
  logic [WIDTH-1:0]   w_ev_data;
  logic               w_ev_we;
  logic               w_od_we;
  logic               w_coll_imm;
  logic               w_coll_addr;
  logic               w_wcoll_nxt;

  assign w_clear = (r_state == RF_CLEAR);

  spu_imm_expand #(
    .WIDTH (WIDTH)
  ) u_imm_expand (
    .i_i16   (i16),
    .i_mode  (imm_mode),
    .o_value (w_imm_value),
    .o_valid (w_imm_valid)
  );

  // Even-slot ownership, r0 suppression and collision detection for this cycle.
  always_comb begin
    w_imm_take  = imm_en && w_imm_valid;
    w_ev_req    = 1'b0;
    w_ev_addr   = wa_e;
    w_ev_data   = wd_e;
    w_ev_we     = 1'b0;
    w_od_we     = 1'b0;
    w_coll_imm  = 1'b0;
    w_coll_addr = 1'b0;
    if (w_clear) begin
      w_ev_req = 1'b0;
    end else begin
      w_ev_req = w_imm_take || we_e;
      if (w_imm_take) begin
        w_ev_addr = rt;
        w_ev_data = w_imm_value;
      end else begin
        w_ev_addr = wa_e;
        w_ev_data = wd_e;
      end
      // Writes aimed at a hard-wired zero r0 vanish before arbitration.
      if ((ZERO_R0 != 0) && (w_ev_addr == ADDR_R0)) begin
        w_ev_we = 1'b0;
      end else begin
        w_ev_we = w_ev_req;
      end
      if ((ZERO_R0 != 0) && (wa_o == ADDR_R0)) begin
        w_od_we = 1'b0;
      end else begin
        w_od_we = we_o;
      end
      // An immediate displacing a live even-pipe write loses wd_e.
      w_coll_imm  = w_imm_take && we_e && w_ev_we;
      w_coll_addr = w_ev_we && w_od_we && (w_ev_addr == wa_o);
    end
    w_wcoll_nxt = w_coll_imm || w_coll_addr;
  end

  // Array update: clear sequencer has exclusive access, otherwise even then odd so odd wins.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_mem[r_cnt] <= {WIDTH{1'b0}};
    end else begin
      if (w_ev_we) begin
        r_mem[w_ev_addr] <= w_ev_data;
      end
      if (w_od_we) begin
        r_mem[wa_o] <= wd_o;
      end
    end
  end

  // Clear sequencer next-state: walk every entry once, restart on request from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RF_IDLE: begin
        if (clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_cnt_nxt   = ADDR_R0;
        end else begin
          w_state_nxt = RF_IDLE;
          w_cnt_nxt   = r_cnt;
        end
      end
      RF_CLEAR: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = RF_IDLE;
        end else begin
          w_state_nxt = RF_CLEAR;
        end
      end
      default: begin
        w_state_nxt = RF_CLEAR;
        w_cnt_nxt   = ADDR_R0;
      end
    endcase
  end

  // Clear sequencer state, counter and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RF_CLEAR;
      r_cnt   <= ADDR_R0;
      r_busy  <= 1'b1;
      r_wcoll <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == RF_CLEAR);
      r_wcoll <= w_wcoll_nxt;
    end
  end

  assign busy  = r_busy;
  assign wcoll = r_wcoll;

  // One registered read port per k; bypass gives odd data priority over even/imm.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [REGBITS-1:0] w_ra;
    logic [WIDTH-1:0]   w_rd_nxt;
    logic [WIDTH-1:0]   r_rd;

    assign w_ra = ra[k*REGBITS +: REGBITS];

    // Select array data, a same-cycle write, or zero for r0 / clear.
    always_comb begin
      w_rd_nxt = r_mem[w_ra];
      if (w_clear) begin
        w_rd_nxt = {WIDTH{1'b0}};
      end else if ((ZERO_R0 != 0) && (w_ra == ADDR_R0)) begin
        w_rd_nxt = {WIDTH{1'b0}};
      end else if (w_od_we && (wa_o == w_ra)) begin
        w_rd_nxt = wd_o;
      end else if (w_ev_we && (w_ev_addr == w_ra)) begin
        w_rd_nxt = w_ev_data;
      end else begin
        w_rd_nxt = r_mem[w_ra];
      end
    end

    // Read data register, one cycle behind the address.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_rd <= {WIDTH{1'b0}};
      end else begin
        r_rd <= w_rd_nxt;
      end
    end

    assign rd[k*WIDTH +: WIDTH] = r_rd;
  end

endmodule

// File: tb/tb_spu_regfile_dp.sv
// Self-checking bench for spu_regfile_dp: directed steps plus randomized
// traffic checked against an array-based reference model every cycle.
module tb_spu_regfile_dp;

  localparam int W  = 128;
  localparam int RB = 7;
  localparam int NR = 4;
  localparam int DP = 128;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR*RB-1:0]  ra = '0;
  wire  [NR*W-1:0]   rd;
  logic              we_e = 1'b0;
  logic [RB-1:0]     wa_e = '0;
  logic [W-1:0]      wd_e = '0;
  logic              we_o = 1'b0;
  logic [RB-1:0]     wa_o = '0;
  logic [W-1:0]      wd_o = '0;
  logic              imm_en = 1'b0;
  logic [1:0]        imm_mode = 2'b00;
  logic [RB-1:0]     rt = '0;
  logic [15:0]       i16 = 16'h0000;
  logic              clr_req = 1'b0;
  wire               busy;
  wire               wcoll;

  spu_regfile_dp dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd),
    .we_e(we_e), .wa_e(wa_e), .wd_e(wd_e),
    .we_o(we_o), .wa_o(wa_o), .wd_o(wd_o),
    .imm_en(imm_en), .imm_mode(imm_mode), .rt(rt), .i16(i16),
    .clr_req(clr_req), .busy(busy), .wcoll(wcoll)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [W-1:0] m [DP];
  logic [RB-1:0] ra_v [NR];
  int clear_left = 0;
  int n_cmp = 0;
  int n_fail = 0;

  localparam logic [W-1:0] VAL_A   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [W-1:0] VAL_B   = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
  localparam logic [W-1:0] IL_C    = {4{32'hFFFF_8001}};
  localparam logic [W-1:0] ILH_C   = {8{16'h8001}};
  localparam logic [W-1:0] ILHU_C  = {4{32'h8001_0000}};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rdp(input int k);
    return rd[k*W +: W];
  endfunction

  // Immediate value computed from the load rules, word by word.
  function automatic logic [W-1:0] imm_ref(input logic [15:0] v, input logic [1:0] md);
    logic [W-1:0] r;
    logic [31:0]  word;
    if (md == 2'd0)      word = {v, v};
    else if (md == 2'd1) word = 32'($signed(v));
    else                 word = {v, 16'h0000};
    for (int w = 0; w < W/32; w++) r[w*32 +: 32] = word;
    return r;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < DP; i++) m[i] = '0;
  endtask

  task automatic idle_inputs();
    we_e = 1'b0; we_o = 1'b0; imm_en = 1'b0; clr_req = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_inputs(input int arange);
    we_e     = 1'($urandom_range(0, 1));
    we_o     = 1'($urandom_range(0, 1));
    imm_en   = 1'($urandom_range(0, 1));
    imm_mode = 2'($urandom_range(0, 3));
    wa_e     = RB'($urandom_range(0, arange - 1));
    wa_o     = RB'($urandom_range(0, arange - 1));
    rt       = RB'($urandom_range(0, arange - 1));
    i16      = 16'($urandom);
    wd_e     = rnd128();
    wd_o     = rnd128();
    clr_req  = 1'b0;
    for (int k = 0; k < NR; k++) ra_v[k] = RB'($urandom_range(0, arange - 1));
  endtask

  // One clock: predict outputs from the model, advance, compare everything.
  task automatic run_cycle();
    logic [W-1:0]  exp_rd [NR];
    logic          exp_wc;
    logic          imm_ok, ev_we;
    logic [RB-1:0] ev_a;
    logic [W-1:0]  ev_d;
    for (int k = 0; k < NR; k++) ra[k*RB +: RB] = ra_v[k];
    if (clear_left > 0) begin
      for (int k = 0; k < NR; k++) exp_rd[k] = '0;
      exp_wc = 1'b0;
      clear_left--;
    end else begin
      imm_ok = imm_en && (imm_mode != 2'b11);
      ev_we  = imm_ok || we_e;
      ev_a   = imm_ok ? rt : wa_e;
      ev_d   = imm_ok ? imm_ref(i16, imm_mode) : wd_e;
      exp_wc = (imm_ok && we_e) || (ev_we && we_o && (ev_a == wa_o));
      for (int k = 0; k < NR; k++) begin
        if (we_o && wa_o == ra_v[k])    exp_rd[k] = wd_o;
        else if (ev_we && ev_a == ra_v[k]) exp_rd[k] = ev_d;
        else                             exp_rd[k] = m[ra_v[k]];
      end
      if (ev_we) m[ev_a] = ev_d;
      if (we_o)  m[wa_o] = wd_o;
      if (clr_req) begin
        clear_left = DP;
        zero_model();
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NR; k++) chk($sformatf("rd%0d", k), rdp(k), exp_rd[k]);
    chk("wcoll", W'(wcoll), W'(exp_wc));
    chk("busy", W'(busy), W'(clear_left > 0));
  endtask

  task automatic read_all();
    idle_inputs();
    for (int i = 0; i < DP / NR; i++) begin
      for (int k = 0; k < NR; k++) ra_v[k] = RB'(i * NR + k);
      run_cycle();
    end
  endtask

  logic [W-1:0] pre;

  initial begin
    for (int k = 0; k < NR; k++) ra_v[k] = '0;
    zero_model();

    // 1: reset state, clear sequence with writes attempted throughout.
    repeat (2) @(negedge clk);
    chk("rst_rd0", rdp(0), '0);
    chk("rst_rd3", rdp(3), '0);
    chk("rst_busy", W'(busy), W'(1'b1));
    chk("rst_wcoll", W'(wcoll), '0);
    reset = 1'b0;
    clear_left = DP;
    for (int i = 0; i < DP; i++) begin
      rand_inputs(DP);
      if (i >= DP / 2) begin
        wa_e = RB'($urandom_range(0, 31));
        wa_o = RB'($urandom_range(0, 31));
        rt   = RB'($urandom_range(0, 31));
      end
      run_cycle();
    end
    read_all();

    // 2: write then read, and same-cycle bypass on every port.
    idle_inputs();
    we_e = 1'b1; wa_e = 7'd5; wd_e = VAL_A;
    for (int k = 0; k < NR; k++) ra_v[k] = 7'd5;
    run_cycle();
    chk("bypass_r5", rdp(0), VAL_A);
    idle_inputs();
    run_cycle();
    chk("read_r5", rdp(0), VAL_A);

    // 3: immediate loads into r9.
    idle_inputs(); imm_en = 1'b1; rt = 7'd9; i16 = 16'h8001; imm_mode = 2'b01;
    run_cycle();
    idle_inputs(); ra_v[1] = 7'd9; run_cycle();
    chk("il_r9", rdp(1), IL_C);
    imm_en = 1'b1; imm_mode = 2'b00; run_cycle();
    idle_inputs(); run_cycle();
    chk("ilh_r9", rdp(1), ILH_C);
    imm_en = 1'b1; imm_mode = 2'b10; run_cycle();
    idle_inputs(); run_cycle();
    chk("ilhu_r9", rdp(1), ILHU_C);
    imm_en = 1'b1; imm_mode = 2'b11; run_cycle();
    idle_inputs(); run_cycle();
    chk("rsv_r9", rdp(1), ILHU_C);

    // 4: same-address even/odd writes, then distinct addresses.
    idle_inputs();
    we_e = 1'b1; wa_e = 7'd7; wd_e = VAL_A;
    we_o = 1'b1; wa_o = 7'd7; wd_o = VAL_B;
    run_cycle();
    chk("coll_pulse", W'(wcoll), W'(1'b1));
    idle_inputs(); ra_v[2] = 7'd7; run_cycle();
    chk("coll_once", W'(wcoll), '0);
    chk("odd_wins_r7", rdp(2), VAL_B);
    we_e = 1'b1; wa_e = 7'd7; wd_e = VAL_A;
    we_o = 1'b1; wa_o = 7'd8; wd_o = VAL_B;
    run_cycle();
    chk("distinct_nocoll", W'(wcoll), '0);
    idle_inputs(); ra_v[0] = 7'd7; ra_v[1] = 7'd8; run_cycle();
    chk("distinct_r7", rdp(0), VAL_A);
    chk("distinct_r8", rdp(1), VAL_B);

    // 5: immediate steals the even slot from we_e.
    pre = m[11];
    idle_inputs();
    imm_en = 1'b1; imm_mode = 2'b01; rt = 7'd10; i16 = 16'h8001;
    we_e = 1'b1; wa_e = 7'd11; wd_e = VAL_B;
    run_cycle();
    chk("imm_steal_coll", W'(wcoll), W'(1'b1));
    idle_inputs(); ra_v[3] = 7'd10; ra_v[0] = 7'd11; run_cycle();
    chk("imm_steal_r10", rdp(3), IL_C);
    chk("imm_steal_r11", rdp(0), pre);

    // Randomized traffic on a narrow address range to force collisions.
    for (int i = 0; i < 300; i++) begin
      rand_inputs(16);
      run_cycle();
    end

    // 6: fill, request clear, reset at cnt=40, full clear after release.
    for (int i = 0; i < DP / 2; i++) begin
      idle_inputs();
      we_e = 1'b1; wa_e = RB'(2 * i); wd_e = rnd128();
      we_o = 1'b1; wa_o = RB'(2 * i + 1); wd_o = rnd128();
      run_cycle();
    end
    idle_inputs(); clr_req = 1'b1; run_cycle();
    for (int i = 0; i < 40; i++) begin
      rand_inputs(DP);
      clr_req = 1'($urandom_range(0, 1));
      run_cycle();
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("midclr_rst_rd0", rdp(0), '0);
    chk("midclr_rst_busy", W'(busy), W'(1'b1));
    chk("midclr_rst_wcoll", W'(wcoll), '0);
    @(negedge clk);
    reset = 1'b0;
    clear_left = DP;
    zero_model();
    for (int i = 0; i < DP; i++) begin
      rand_inputs(DP);
      run_cycle();
    end
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
